// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the execute-stage branch logic: branch funct3
// encodings, the default datapath width and the control-transfer op type.
package rv32i_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_BRANCH,
    OP_JAL,
    OP_JALR
  } op_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation from the raw operands; funct3
// codes 010/011 are reserved and reported as illegal (never taken).
module branch_cond
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign rs1_s = rs1_i;
  assign rs2_s = rs2_i;
  assign eq    = (rs1_i == rs2_i);
  assign lt_s  = (rs1_s < rs2_s);
  assign lt_u  = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolution: target and link generation, prediction
// check with a one-cycle flush strobe, optional output register, perf counters.
module branch_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int PIPE  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             take_branch_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [XLEN-1:0]  link_o,
  output logic             mispredict_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic             illegal_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef struct packed {
    logic            take;
    logic [XLEN-1:0] redirect;
    logic [XLEN-1:0] link;
    logic            mispredict;
    logic            misalign;
    logic            illegal;
    logic            counted;
  } res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  op_e             op_c;
  logic            cond_taken;
  logic            cond_illegal;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  res_t            res_c;
  res_t            res_o;
  logic            hs;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .funct3_i  (funct3_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  always_comb begin
    op_c = OP_NONE;
    if (jump_i) begin
      op_c = jalr_i ? OP_JALR : OP_JAL;
    end else if (branch_i) begin
      op_c = OP_BRANCH;
    end
  end

  assign pc_plus4  = pc_i + XLEN'(4);
  assign pc_target = pc_i + imm_i;
  assign jalr_sum  = rs1_i + imm_i;

  // Resolution: a misaligned or illegal op goes to the trap path, so it must
  // neither flag a mispredict nor redirect the front end.
  always_comb begin
    res_c      = '0;
    target     = pc_target;
    res_c.link = pc_plus4;
    case (op_c)
      OP_BRANCH: begin
        res_c.take    = cond_taken;
        res_c.illegal = cond_illegal;
      end
      OP_JAL:  res_c.take = 1'b1;
      OP_JALR: begin
        res_c.take = 1'b1;
        target     = jalr_sum & ~XLEN'(1);
      end
      default: ;
    endcase
    res_c.redirect   = res_c.take ? target : pc_plus4;
    res_c.misalign   = res_c.take && target[1];
    res_c.mispredict = !res_c.misalign && !res_c.illegal &&
                       ((res_c.take != pred_taken_i) ||
                        (res_c.take && pred_taken_i && (target != pred_target_i)));
    res_c.counted    = (op_c != OP_NONE) && !res_c.illegal;
  end

  if (PIPE != 0) begin : g_pipe
    logic vld_q, vld_d;
    res_t res_q, res_d;

    assign ready_o = !vld_q || ready_i;

    always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      if (valid_i && ready_o) begin
        vld_d = 1'b1;
        res_d = res_c;
      end else if (ready_i) begin
        vld_d = 1'b0;
      end
    end

    // Output register stage boundary
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        res_q <= res_d;
      end
    end

    assign valid_o = vld_q;
    assign res_o   = res_q;
  end else begin : g_comb
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign res_o   = res_c;
  end

  assign hs      = valid_o && ready_i;
  assign flush_o = hs && res_o.mispredict && !rst_i;

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (clr_cnt_i) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else begin
      if (hs && res_o.counted) bcnt_d = sat_inc(bcnt_q);
      if (flush_o)             mcnt_d = sat_inc(mcnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign take_branch_o    = res_o.take;
  assign redirect_pc_o    = res_o.redirect;
  assign link_o           = res_o.link;
  assign mispredict_o     = res_o.mispredict;
  assign misalign_o       = res_o.misalign;
  assign illegal_o        = res_o.illegal;
  assign branch_cnt_o     = bcnt_q;
  assign mispredict_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit (PIPE=1): a reference model pushes the
// expected result on each accepted op and it is compared while it is presented.
module tb_branch_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_i, valid_i, ready_o, branch_i, jump_i, jalr_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i, rs2_i, pc_i, imm_i, pred_target_i;
  logic             pred_taken_i;
  logic             valid_o, ready_i, take_branch_o;
  logic [XLEN-1:0]  redirect_pc_o, link_o;
  logic             mispredict_o, flush_o, misalign_o, illegal_o, clr_cnt_i;
  logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(XLEN), .PIPE(1), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .branch_i(branch_i), .jump_i(jump_i), .jalr_i(jalr_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imm_i(imm_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .valid_o(valid_o), .ready_i(ready_i), .take_branch_o(take_branch_o),
    .redirect_pc_o(redirect_pc_o), .link_o(link_o), .mispredict_o(mispredict_o),
    .flush_o(flush_o), .misalign_o(misalign_o), .illegal_o(illegal_o),
    .clr_cnt_i(clr_cnt_i), .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  typedef struct packed {
    logic        take;
    logic [31:0] redir;
    logic [31:0] link;
    logic        mis;
    logic        misal;
    logic        ill;
    logic        cnt;
  } res_t;

  res_t             sb_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_bcnt = '0;
  logic [CNT_W-1:0] exp_mcnt = '0;
  logic [31:0]      pool [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model();
    res_t        r;
    logic [31:0] tgt;
    logic        mis;
    r      = '0;
    r.link = pc_i + 32'd4;
    tgt    = pc_i + imm_i;
    if (jump_i) begin
      r.take = 1'b1;
      r.cnt  = 1'b1;
      if (jalr_i) tgt = (rs1_i + imm_i) & 32'hFFFF_FFFE;
    end else if (branch_i) begin
      r.cnt = 1'b1;
      case (funct3_i)
        3'd0: r.take = (rs1_i == rs2_i);
        3'd1: r.take = (rs1_i != rs2_i);
        3'd4: r.take = ($signed(rs1_i) <  $signed(rs2_i));
        3'd5: r.take = ($signed(rs1_i) >= $signed(rs2_i));
        3'd6: r.take = (rs1_i <  rs2_i);
        3'd7: r.take = (rs1_i >= rs2_i);
        default: begin r.ill = 1'b1; r.cnt = 1'b0; end
      endcase
    end
    r.redir = r.take ? tgt : r.link;
    r.misal = r.take && tgt[1];
    mis     = (r.take != pred_taken_i) || (r.take && pred_taken_i && (tgt != pred_target_i));
    r.mis   = mis && !r.misal && !r.ill;
    return r;
  endfunction

  // One clock: compare at the negedge, advance the model, return at posedge+1.
  task automatic cycle();
    res_t h;
    bit   has, hs, acc, fl;
    h = '0;
    @(negedge clk);
    has = (sb_q.size() != 0);
    if (has) h = sb_q[0];
    check("valid_o", 32'(valid_o), 32'(has));
    check("ready_o", 32'(ready_o), 32'(!has || ready_i));
    if (has) begin
      check("take",     32'(take_branch_o), 32'(h.take));
      check("redirect", redirect_pc_o,      h.redir);
      check("link",     link_o,             h.link);
      check("mispred",  32'(mispredict_o),  32'(h.mis));
      check("misalign", 32'(misalign_o),    32'(h.misal));
      check("illegal",  32'(illegal_o),     32'(h.ill));
    end
    hs  = has && ready_i;
    fl  = hs && h.mis && !rst_i;
    acc = valid_i && (!has || ready_i);
    check("flush_o",  32'(flush_o),          32'(fl));
    check("br_cnt",   32'(branch_cnt_o),     32'(exp_bcnt));
    check("mis_cnt",  32'(mispredict_cnt_o), 32'(exp_mcnt));
    if (rst_i) begin
      sb_q.delete();
      exp_bcnt = '0;
      exp_mcnt = '0;
    end else begin
      if (clr_cnt_i) begin
        exp_bcnt = '0;
        exp_mcnt = '0;
      end else begin
        if (hs && h.cnt && exp_bcnt != '1) exp_bcnt = exp_bcnt + 1'b1;
        if (fl && exp_mcnt != '1)          exp_mcnt = exp_mcnt + 1'b1;
      end
      if (hs)  void'(sb_q.pop_front());
      if (acc) sb_q.push_back(model());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic br, input logic j, input logic jr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
    valid_i = 1'b1; branch_i = br; jump_i = j; jalr_i = jr; funct3_i = f3;
    rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm; pred_taken_i = pt; pred_target_i = ptgt;
  endtask

  task automatic idle();
    valid_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; jalr_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; ready_i = 1'b1; clr_cnt_i = 1'b0;
    idle();
    funct3_i = '0; rs1_i = '0; rs2_i = '0; pc_i = '0; imm_i = '0;
    pred_taken_i = 1'b0; pred_target_i = '0;
    cycle(); cycle();
    check("rst_valid",  32'(valid_o), 0);
    check("rst_flush",  32'(flush_o), 0);
    check("rst_take",   32'(take_branch_o), 0);
    check("rst_redir",  redirect_pc_o, 0);
    check("rst_link",   link_o, 0);
    check("rst_flags",  {29'd0, mispredict_o, misalign_o, illegal_o}, 0);
    check("rst_cnts",   {branch_cnt_o, mispredict_cnt_o}, 0);
    rst_i = 1'b0;
    cycle();

    // BEQ taken but predicted not-taken
    drive_op(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h0);
    cycle();
    check("beq_take",  32'(take_branch_o), 1);
    check("beq_redir", redirect_pc_o, 32'h120);
    check("beq_flush", 32'(flush_o), 1);
    idle();
    cycle();
    check("beq_mcnt",   32'(mispredict_cnt_o), 1);
    check("beq_noflush", 32'(flush_o), 0);

    // Signed vs unsigned less-than on the same operands
    drive_op(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1, 32'h240);
    cycle();
    check("blt_take", 32'(take_branch_o), 1);
    check("blt_mis",  32'(mispredict_o), 0);
    drive_op(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 32'h0);
    cycle();
    check("bltu_take",  32'(take_branch_o), 0);
    check("bltu_redir", redirect_pc_o, 32'h204);
    check("bltu_flush", 32'(flush_o), 0);

    // JALR to a halfword-aligned target
    drive_op(0, 1, 1, 3'b000, 32'h203, 32'h0, 32'h400, 32'h0, 0, 32'h0);
    cycle();
    check("jalr_redir", redirect_pc_o, 32'h202);
    check("jalr_mal",   32'(misalign_o), 1);
    check("jalr_flush", 32'(flush_o), 0);
    check("jalr_link",  link_o, 32'h404);

    // Reserved funct3
    drive_op(1, 0, 0, 3'b010, 32'd3, 32'd3, 32'h600, 32'h8, 1, 32'h608);
    cycle();
    check("ill_flag", 32'(illegal_o), 1);
    check("ill_take", 32'(take_branch_o), 0);
    check("ill_mis",  32'(mispredict_o), 0);
    idle();
    cycle();
    check("ill_bcnt", 32'(branch_cnt_o), 4);

    // Stall a mispredicting result for three cycles with a second op waiting
    ready_i = 1'b0;
    drive_op(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 0, 32'h0);
    cycle();
    drive_op(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h500, 32'h10, 1, 32'h510);
    repeat (3) cycle();
    check("stall_ready", 32'(ready_o), 0);
    check("stall_flush", 32'(flush_o), 0);
    ready_i = 1'b1;
    #1;
    check("release_flush", 32'(flush_o), 1);
    cycle();
    check("b2b_redir", redirect_pc_o, 32'h510);
    idle();
    cycle();

    // Mixed random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 32'($urandom_range(0, 255)) - 32'd128,
                 1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      else
        idle();
      cycle();
    end
    ready_i = 1'b1;
    idle();
    cycle(); cycle();

    // Clear wins over a same-cycle increment
    drive_op(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h700, 32'h10, 1, 32'h710);
    cycle();
    idle();
    clr_cnt_i = 1'b1;
    cycle();
    clr_cnt_i = 1'b0;
    check("clr_bcnt", 32'(branch_cnt_o), 0);

    // Saturate the branch counter
    for (int i = 0; i < 65535; i++) begin
      drive_op(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h800, 32'h10, 1, 32'h810);
      cycle();
    end
    idle();
    cycle();
    check("sat_full", 32'(branch_cnt_o), 32'hFFFF);
    drive_op(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h800, 32'h10, 1, 32'h810);
    cycle();
    idle();
    cycle();
    check("sat_hold", 32'(branch_cnt_o), 32'hFFFF);

    // Reset while a mispredicting result is stalled
    ready_i = 1'b0;
    drive_op(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h900, 32'h40, 0, 32'h0);
    cycle();
    idle();
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check("rst_stall_valid", 32'(valid_o), 0);
    check("rst_stall_flush", 32'(flush_o), 0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
